// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD digit width, wrap-mode encoding and decimal-to-BCD conversion
package clock_pkg;
   localparam int DIGIT_W = 4;
   localparam int MAX_DIGITS = 8;
   localparam bit WRAP_SAT = 1'b0;
   localparam bit WRAP_ROLL = 1'b1;
   function automatic logic [DIGIT_W*MAX_DIGITS-1:0] to_bcd(input int unsigned v);
      logic [DIGIT_W*MAX_DIGITS-1:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit with load, ripple-in step and ripple-out
module bcd_digit
   import clock_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_val_i,
   input  logic               step_i,
   input  logic               up_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               ripple_o
);
   logic [DIGIT_W-1:0] digit_q, digit_d;
   logic at_nine, at_zero;
   assign at_nine = digit_q == DIGIT_W'(9);
   assign at_zero = digit_q == '0;
   always_comb
      digit_d = load_i  ? load_val_i :
                !step_i ? digit_q :
                up_i    ? (at_nine ? '0 : digit_q + DIGIT_W'(1)) :
                          (at_zero ? DIGIT_W'(9) : digit_q - DIGIT_W'(1));
   always_ff @(posedge clk or posedge rst)
      if (rst) digit_q <= RST_VAL;
      else     digit_q <= digit_d;
   assign ripple_o = step_i & (up_i ? at_nine : at_zero);
   assign digit_o = digit_q;
endmodule

// File: rtl/time_field_counter.sv
// time_field_counter: bounded BCD up/down counter with wrap/saturate, load checking
// and combinational terminal count for zero-cycle cascading.
module time_field_counter
   import clock_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int MIN_VALUE  = 0,
   parameter int MAX_VALUE  = 59,
   parameter int WRAP       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          enable,
   input  logic                          up_down,
   input  logic                          load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
   output logic [DIGIT_W*NUM_DIGITS-1:0] count_bcd,
   output logic                          tc,
   output logic                          carry,
   output logic                          borrow,
   output logic                          load_err
);
   localparam int W = DIGIT_W * NUM_DIGITS;
   localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MIN_VALUE));
   localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VALUE));
   localparam bit ROLL = (WRAP == int'(WRAP_ROLL));
   logic [W-1:0] count, dig_val;
   logic [W:0] lo_diff, hi_diff;
   logic [NUM_DIGITS-1:0] ripple;
   logic digits_ok, load_ok, wrap_up, wrap_dn, quiet, dig_load, step0;
   logic carry_q, carry_d, borrow_q, borrow_d, load_err_q, load_err_d;
   // BCD with all digits <= 9 orders like binary, so bound checks use plain subtraction
   assign lo_diff = {1'b0, load_value} - {1'b0, MIN_BCD};
   assign hi_diff = {1'b0, MAX_BCD} - {1'b0, load_value};
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         digits_ok = digits_ok & (load_value[DIGIT_W*i +: DIGIT_W] <= DIGIT_W'(9));
      load_ok = digits_ok & ~lo_diff[W] & ~hi_diff[W];
      wrap_up = enable & up_down & (count == MAX_BCD);
      wrap_dn = enable & ~up_down & (count == MIN_BCD);
      quiet = ~clear & ~load;
      dig_load = clear | (load & load_ok) | (quiet & ROLL & (wrap_up | wrap_dn));
      dig_val = clear ? MIN_BCD : load ? load_value : wrap_up ? MIN_BCD : MAX_BCD;
      step0 = quiet & enable & ~wrap_up & ~wrap_dn;
      carry_d = quiet & ROLL & (wrap_up | (up_down & ripple[NUM_DIGITS-1]));
      borrow_d = quiet & ROLL & (wrap_dn | (~up_down & ripple[NUM_DIGITS-1]));
      load_err_d = ~clear & load & ~load_ok;
   end
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      logic step;
      if (d == 0) begin : g_first
         assign step = step0;
      end else begin : g_rest
         assign step = ripple[d-1];
      end
      bcd_digit #(.RST_VAL(MIN_BCD[DIGIT_W*d +: DIGIT_W])) u_digit (
         .clk       (clk),
         .rst       (rst),
         .load_i    (dig_load),
         .load_val_i(dig_val[DIGIT_W*d +: DIGIT_W]),
         .step_i    (step),
         .up_i      (up_down),
         .digit_o   (count[DIGIT_W*d +: DIGIT_W]),
         .ripple_o  (ripple[d])
      );
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         load_err_q <= load_err_d;
      end
   assign count_bcd = count;
   assign tc = wrap_up | wrap_dn;
   assign carry = carry_q;
   assign borrow = borrow_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_time_field_counter.sv
// tb_time_field_counter: directed checks of a 00-59 wrap counter, a 01-12 saturating
// counter and a 60x24 cascade driven from the first counter's tc.
module tb_time_field_counter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic clear, enable, up_down, load, tc, carry, borrow, load_err;
   logic [7:0] load_value, count;
   logic s_clear, s_enable, s_up, s_load, s_tc, s_carry, s_borrow, s_err;
   logic [7:0] s_lv, s_count;
   logic h_tc, h_carry, h_borrow, h_err;
   logic [7:0] h_count;
   int total = 0;
   int bad = 0;

   time_field_counter dut (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable), .up_down(up_down),
      .load(load), .load_value(load_value), .count_bcd(count), .tc(tc),
      .carry(carry), .borrow(borrow), .load_err(load_err)
   );
   time_field_counter #(.NUM_DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(12), .WRAP(0)) sat (
      .clk(clk), .rst(rst), .clear(s_clear), .enable(s_enable), .up_down(s_up),
      .load(s_load), .load_value(s_lv), .count_bcd(s_count), .tc(s_tc),
      .carry(s_carry), .borrow(s_borrow), .load_err(s_err)
   );
   time_field_counter #(.NUM_DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(23), .WRAP(1)) hr (
      .clk(clk), .rst(rst), .clear(1'b0), .enable(tc), .up_down(1'b1),
      .load(1'b0), .load_value(8'h00), .count_bcd(h_count), .tc(h_tc),
      .carry(h_carry), .borrow(h_borrow), .load_err(h_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      {clear, enable, up_down, load} = '0;
      load_value = 8'h00;
      {s_clear, s_enable, s_up, s_load} = '0;
      s_lv = 8'h00;
      #2 rst = 1'b1;
      #1;
      chk("rst_count", count, 8'h00);
      chk("rst_flags", {carry, borrow, load_err}, 3'b000);
      chk("rst_sat_count", s_count, 8'h01);
      chk("rst_hr_count", h_count, 8'h00);
      tick();
      tick();
      rst = 1'b0;
      // count up through the wrap
      enable = 1'b1;
      up_down = 1'b1;
      repeat (58) tick();
      chk("up58", count, 8'h58);
      chk("up58_tc", tc, 1'b0);
      tick();
      chk("up59", count, 8'h59);
      chk("up59_tc", tc, 1'b1);
      tick();
      chk("wrap_count", count, 8'h00);
      chk("wrap_carry", carry, 1'b1);
      tick();
      chk("post_wrap_count", count, 8'h01);
      chk("post_wrap_carry", carry, 1'b0);
      // async reset between edges while a wrap is pending
      enable = 1'b0;
      load = 1'b1;
      load_value = 8'h59;
      tick();
      load = 1'b0;
      chk("load59", count, 8'h59);
      enable = 1'b1;
      #3 rst = 1'b1;
      #1;
      chk("async_rst_count", count, 8'h00);
      chk("async_rst_carry", carry, 1'b0);
      tick();
      chk("rst_hold_carry", carry, 1'b0);
      chk("rst_hold_count", count, 8'h00);
      rst = 1'b0;
      enable = 1'b0;
      // count down through the borrow
      load = 1'b1;
      load_value = 8'h05;
      tick();
      load = 1'b0;
      chk("load05", count, 8'h05);
      enable = 1'b1;
      up_down = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("down", count, 32'(5 - i));
      end
      chk("down_tc", tc, 1'b1);
      tick();
      chk("borrow_count", count, 8'h59);
      chk("borrow_pulse", borrow, 1'b1);
      tick();
      chk("post_borrow_count", count, 8'h58);
      chk("post_borrow_pulse", borrow, 1'b0);
      enable = 1'b0;
      // rejected and accepted loads
      load = 1'b1;
      load_value = 8'h7A;
      tick();
      chk("bad_digit_count", count, 8'h58);
      chk("bad_digit_err", load_err, 1'b1);
      load = 1'b0;
      tick();
      chk("err_drop", load_err, 1'b0);
      load = 1'b1;
      load_value = 8'h60;
      enable = 1'b1;
      up_down = 1'b1;
      tick();
      chk("over_max_count", count, 8'h58);
      chk("over_max_err", load_err, 1'b1);
      load_value = 8'h30;
      tick();
      chk("load30", count, 8'h30);
      chk("load30_err", load_err, 1'b0);
      load = 1'b0;
      enable = 1'b0;
      tick();
      chk("hold30", count, 8'h30);
      // clear beats an enabled wrap and suppresses carry
      load = 1'b1;
      load_value = 8'h59;
      tick();
      load = 1'b0;
      clear = 1'b1;
      enable = 1'b1;
      tick();
      chk("clear_count", count, 8'h00);
      chk("clear_carry", carry, 1'b0);
      clear = 1'b0;
      enable = 1'b0;
      // saturating 01..12 instance
      s_enable = 1'b1;
      s_up = 1'b1;
      repeat (15) begin
         tick();
         chk("sat_no_carry", s_carry, 1'b0);
      end
      chk("sat_max", s_count, 8'h12);
      chk("sat_max_tc", s_tc, 1'b1);
      s_enable = 1'b0;
      s_clear = 1'b1;
      tick();
      chk("sat_clear", s_count, 8'h01);
      s_clear = 1'b0;
      s_enable = 1'b1;
      s_up = 1'b0;
      #1;
      chk("sat_min_tc", s_tc, 1'b1);
      tick();
      chk("sat_min_hold", s_count, 8'h01);
      chk("sat_no_borrow", s_borrow, 1'b0);
      s_enable = 1'b0;
      s_load = 1'b1;
      s_lv = 8'h09;
      tick();
      s_load = 1'b0;
      s_enable = 1'b1;
      s_up = 1'b1;
      tick();
      chk("ripple_09_10", s_count, 8'h10);
      s_up = 1'b0;
      tick();
      chk("ripple_10_09", s_count, 8'h09);
      s_enable = 1'b0;
      s_load = 1'b1;
      s_lv = 8'h00;
      tick();
      chk("sat_below_min_count", s_count, 8'h09);
      chk("sat_below_min_err", s_err, 1'b1);
      s_load = 1'b0;
      // 60 x 24 cascade
      rst = 1'b1;
      tick();
      rst = 1'b0;
      enable = 1'b1;
      up_down = 1'b1;
      repeat (60) tick();
      chk("casc60_min", count, 8'h00);
      chk("casc60_hr", h_count, 8'h01);
      repeat (1379) tick();
      chk("casc1439", {h_count, count}, 16'h2359);
      tick();
      chk("casc1440", {h_count, count}, 16'h0000);
      enable = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/time_field_counter.md
TIME_FIELD_COUNTER -- requirements
Module: time_field_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of BCD digits held.
REQ-002 SHALL have parameter MIN_VALUE, default 0: lowest legal count (decimal).
REQ-003 SHALL have parameter MAX_VALUE, default 59: highest legal count (decimal); MIN_VALUE < MAX_VALUE <= 10^NUM_DIGITS-1.
REQ-004 SHALL have parameter WRAP, default 1: 1 = wrap at bounds, 0 = saturate at bounds.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-007 SHALL have port clear, input, 1: synchronous return to MIN_VALUE.
REQ-008 SHALL have port enable, input, 1: count one step this cycle.
REQ-009 SHALL have port up_down, input, 1: step direction; 1 = up, 0 = down.
REQ-010 SHALL have port load, input, 1: synchronous load request.
REQ-011 SHALL have port load_value, input, 4*NUM_DIGITS: BCD value to load; digit 0 in bits [3:0].
REQ-012 SHALL have port count_bcd, output, 4*NUM_DIGITS: registered BCD count.
REQ-013 SHALL have port tc, output, 1: combinational terminal count; high when enable=1 and (up_down=1 and count=MAX_VALUE) or (up_down=0 and count=MIN_VALUE).
REQ-014 SHALL have port carry, output, 1: registered one-cycle pulse after an up-wrap.
REQ-015 SHALL have port borrow, output, 1: registered one-cycle pulse after a down-wrap.
REQ-016 SHALL have port load_err, output, 1: registered one-cycle pulse after a rejected load.

Function
REQ-017 SHALL apply priority rst > clear > load > enable each cycle.
REQ-018 SHALL keep count_bcd a valid BCD value in [MIN_VALUE, MAX_VALUE] at all times.
REQ-019 SHALL increment (up_down=1) or decrement (up_down=0) count_bcd by exactly one when enable=1 and no higher-priority input is active; digit ripple follows BCD rules (09->10, 10->09).
REQ-020 SHALL, with WRAP=1, step MAX_VALUE->MIN_VALUE on up and assert carry on the next cycle, coincident with count_bcd=MIN_VALUE.
REQ-021 SHALL, with WRAP=1, step MIN_VALUE->MAX_VALUE on down and assert borrow on the next cycle, coincident with count_bcd=MAX_VALUE.
REQ-022 SHALL, with WRAP=0, hold at the bound; carry and borrow stay low; tc still asserts.
REQ-023 SHALL accept load only when every load_value digit is <=9 and the value lies in [MIN_VALUE, MAX_VALUE]; count_bcd takes load_value next cycle.
REQ-024 SHALL reject any other load: count_bcd unchanged, load_err pulses one cycle, enable ignored that cycle.
REQ-025 SHALL hold count_bcd when enable=0 and no clear/load.
REQ-026 SHALL drive carry, borrow and load_err low in every cycle not named in REQ-020/021/024, including cycles with clear active.
REQ-027 SHALL allow cascading: next stage enable = this stage's tc gives zero-cycle ripple.

Reset
REQ-028 SHALL, on rst=1, immediately set count_bcd=MIN_VALUE (BCD) and carry=borrow=load_err=0, independent of clk.
REQ-029 SHALL ignore all inputs while rst=1 and resume on the first rising edge after deassertion; reset mid-wrap suppresses the pending carry/borrow.

Structure
REQ-030 SHALL take BCD digit width (4), the BCD conversion function for MIN/MAX parameters and the WRAP encoding constants from shared package clock_pkg.
REQ-031 SHALL instantiate NUM_DIGITS copies of sub-module bcd_digit (one digit, up/down, ripple-in/ripple-out, load); bound detection and wrap/saturate logic live in time_field_counter.

Verification
REQ-032 SHALL cover: defaults, count up 58 cycles from reset -> count_bcd=0x58; one more -> 0x59, tc=1; next edge -> 0x00, carry=1 for one cycle.
REQ-033 SHALL cover: defaults, load 0x05, up_down=0 x6 -> 0x04..0x00 then 0x59 with borrow=1 one cycle.
REQ-034 SHALL cover: load 0x7A or 0x60 (MAX=59) -> count unchanged, load_err=1 one cycle; load 0x30 with enable=1 -> 0x30, no step.
REQ-035 SHALL cover: MIN=1, MAX=12, WRAP=0, count up from 1 -> holds at 0x12, carry never asserts; clear -> 0x01.
REQ-036 SHALL cover: rst asserted between clock edges at count 0x59 with enable=1 -> count_bcd=0x00 before next edge, carry stays 0.
REQ-037 SHALL cover: two instances cascaded via tc (60 and 24 defaults) run 1440 enables -> both return to 0x00 together.
